// File: rtl/sys_bus_pkg.sv
// Shared types and default widths for the system-bus initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sys_bus_pkg;

   localparam int SYS_AW = 32;
   localparam int SYS_DW = 32;

   // One transaction in flight at a time walks IDLE -> ISSUE -> WAIT -> RESP.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [SYS_AW-1:0]     addr;
      logic [SYS_DW-1:0]     wdata;
      logic [SYS_DW/8-1:0]   sel;
   } cmd_t;

   typedef struct packed {
      logic [SYS_DW-1:0]     rdata;
      logic                  err;
      logic                  tmo;
   } rsp_t;

endpackage

// File: rtl/sys_bus_tmo_cnt.sv
// Watchdog counter: counts enabled cycles after a clear and flags the LIMIT-th one.
// Latency: expired is combinational in the cycle whose count would reach LIMIT.
// Backpressure: none; clr has priority over en.
module sys_bus_tmo_cnt #(
   parameter int W     = 8,
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   // Count enabled cycles since the last clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

   // The current enabled cycle is the LIMIT-th one since the clear.
   assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/sys_bus_initiator.sv
// Single-outstanding master: valid/ready command -> one sys_wen/sys_ren strobe -> valid/ready response.
// Latency: strobe 1 cycle after accept, response 1 cycle after ack (4-cycle turn with a 1-cycle responder).
// Backpressure: cmd_ready_o low from accept until the response is consumed; response held while rsp_ready_i low.
// Build option SYS_BUS_INIT_TIMEOUT_EN adds a watchdog that ends WAIT after TMO_CYC cycles with err=1, tmo=1.
module sys_bus_initiator
   import sys_bus_pkg::*;
#(
   parameter int AW      = SYS_AW,
   parameter int DW      = SYS_DW,
   parameter int TMO_W   = 8,
   parameter int TMO_CYC = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_we_i,
   input  logic [AW-1:0]   cmd_addr_i,
   input  logic [DW-1:0]   cmd_wdata_i,
   input  logic [DW/8-1:0] cmd_sel_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_rdata_o,
   output logic            rsp_err_o,
   output logic            rsp_tmo_o,
   output logic [AW-1:0]   sys_addr_o,
   output logic [DW-1:0]   sys_wdata_o,
   output logic [DW/8-1:0] sys_sel_o,
   output logic            sys_wen_o,
   output logic            sys_ren_o,
   input  logic [DW-1:0]   sys_rdata_i,
   input  logic            sys_err_i,
   input  logic            sys_ack_i
);

   state_t            state, state_nxt;
   logic              rdy_en;
   logic              we_q;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     wdata_q;
   logic [DW/8-1:0]   sel_q;
   logic [DW-1:0]     rdata_q;
   logic              err_q;
   logic              cmd_acc;
   logic              bus_done;
   logic              tmo_hit;
   logic              wait_end;

   assign cmd_ready_o = (state == IDLE) && rdy_en;
   assign cmd_acc     = cmd_ready_o && cmd_valid_i;
   // Responder returns only count while waiting; stray or late acks are dropped.
   assign bus_done    = (state == WAIT) && (sys_ack_i || sys_err_i);
   assign wait_end    = bus_done || tmo_hit;

`ifdef SYS_BUS_INIT_TIMEOUT_EN
   logic tmo_exp;
   logic tmo_q;

   sys_bus_tmo_cnt #(
      .W     (TMO_W),
      .LIMIT (TMO_CYC)
   ) u_tmo_cnt (
      .clk     (clk_i),
      .rst     (rst_i),
      .clr     (state == ISSUE),
      .en      (state == WAIT),
      .expired (tmo_exp)
   );

   // An ack or err in the expiry cycle wins over the watchdog.
   assign tmo_hit = tmo_exp && !(sys_ack_i || sys_err_i);

   // Remember whether the transaction ended by watchdog.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_q <= 1'b0;
      end else if (wait_end) begin
         tmo_q <= tmo_hit;
      end
   end

   assign rsp_tmo_o = tmo_q;
`else
   assign tmo_hit   = 1'b0;
   assign rsp_tmo_o = 1'b0;
`endif

   // Hold cmd_ready_o low until the first clock edge after reset is released.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: one strobe cycle, then wait for the responder, then hand off the response.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_acc)     state_nxt = ISSUE;
         ISSUE:                    state_nxt = WAIT;
         WAIT:    if (wait_end)    state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Latch the command on accept; the bus request fields stay put until the next accept.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
      end else if (cmd_acc) begin
         we_q    <= cmd_we_i;
         addr_q  <= cmd_addr_i;
         wdata_q <= cmd_wdata_i;
         sel_q   <= cmd_sel_i;
      end
   end

   // Capture the outcome when WAIT ends; read data only for acked reads.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (wait_end) begin
         rdata_q <= (sys_ack_i && !we_q) ? sys_rdata_i : '0;
         err_q   <= sys_err_i || tmo_hit;
      end
   end

   assign sys_wen_o   = (state == ISSUE) && we_q;
   assign sys_ren_o   = (state == ISSUE) && !we_q;
   assign sys_addr_o  = addr_q;
   assign sys_wdata_o = wdata_q;
   assign sys_sel_o   = sel_q;
   assign rsp_valid_o = (state == RESP);
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Bench for sys_bus_initiator: directed commands, 1-cycle responder model, scoreboard on the response stream.
// Latency: expects strobe at N+1 and response at N+3 for a handshake at N.
// Backpressure: exercises rsp_ready_i held low with a queued command.
`timescale 1ns/1ps
module tb_sys_bus_initiator;
   import sys_bus_pkg::*;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TMO_CYC = 64;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            cmd_valid_i = 1'b0;
   logic            cmd_ready_o;
   logic            cmd_we_i = 1'b0;
   logic [AW-1:0]   cmd_addr_i = '0;
   logic [DW-1:0]   cmd_wdata_i = '0;
   logic [DW/8-1:0] cmd_sel_i = '0;
   logic            rsp_valid_o;
   logic            rsp_ready_i = 1'b1;
   logic [DW-1:0]   rsp_rdata_o;
   logic            rsp_err_o;
   logic            rsp_tmo_o;
   logic [AW-1:0]   sys_addr_o;
   logic [DW-1:0]   sys_wdata_o;
   logic [DW/8-1:0] sys_sel_o;
   logic            sys_wen_o;
   logic            sys_ren_o;
   logic [DW-1:0]   sys_rdata_i = '0;
   logic            sys_err_i = 1'b0;
   logic            sys_ack_i = 1'b0;

   int              checks = 0;
   int              errors = 0;
   rsp_t            exp_q[$];
   logic            auto_ack = 1'b1;
   logic [DW-1:0]   model_rdata = '0;
   logic            model_err = 1'b0;

   always #5 clk = ~clk;

   sys_bus_initiator #(
      .AW      (AW),
      .DW      (DW),
      .TMO_W   (8),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_wdata_i (cmd_wdata_i),
      .cmd_sel_i   (cmd_sel_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_tmo_o   (rsp_tmo_o),
      .sys_addr_o  (sys_addr_o),
      .sys_wdata_o (sys_wdata_o),
      .sys_sel_o   (sys_sel_o),
      .sys_wen_o   (sys_wen_o),
      .sys_ren_o   (sys_ren_o),
      .sys_rdata_i (sys_rdata_i),
      .sys_err_i   (sys_err_i),
      .sys_ack_i   (sys_ack_i)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic cmd_t mk_cmd(input logic we, input logic [31:0] a, input logic [31:0] w,
                                   input logic [3:0] s);
      cmd_t c;
      c.we    = we;
      c.addr  = a;
      c.wdata = w;
      c.sel   = s;
      return c;
   endfunction

   task automatic expect_rsp(input logic [31:0] r, input logic e, input logic t);
      rsp_t x;
      x.rdata = r;
      x.err   = e;
      x.tmo   = t;
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input cmd_t c);
      cmd_valid_i = 1'b1;
      cmd_we_i    = c.we;
      cmd_addr_i  = c.addr;
      cmd_wdata_i = c.wdata;
      cmd_sel_i   = c.sel;
   endtask

   // Returns just after the accepting edge, i.e. inside the ISSUE cycle.
   task automatic wait_accept();
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready_o) check("cmd_accept_bound", cmd_ready_o, 1);
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic issue(input cmd_t c);
      drive(c);
      wait_accept();
   endtask

   // Responder: registered ack one cycle after any strobe while auto_ack is set.
   initial begin : responder
      logic pend;
      forever begin
         @(negedge clk);
         pend = sys_wen_o || sys_ren_o;
         tick();
         if (auto_ack) begin
            sys_ack_i   = pend;
            sys_err_i   = pend && model_err;
            sys_rdata_i = pend ? model_rdata : '0;
         end
      end
   end

   // Scoreboard monitor: compare every consumed response with the oldest expectation.
   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid_o && rsp_ready_i && !rst_i) begin
            check("rsp_expected_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata_o, e.rdata);
               check("rsp_err", rsp_err_o, e.err);
               check("rsp_tmo", rsp_tmo_o, e.tmo);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog sim_time=%0t required_end_before=%0t", $time, 64'd500000);
      $fatal(1, "bench watchdog expired");
   end

   initial begin : main
      int n;
      int seen;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_sys_wen", sys_wen_o, 0);
      check("rst_sys_ren", sys_ren_o, 0);
      check("rst_sys_addr", sys_addr_o, 0);
      check("rst_rsp_rdata", rsp_rdata_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      check("rst_rsp_tmo", rsp_tmo_o, 0);
      rst_i = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready_o, 1);

      // Read addr 0, responder returns 1: strobe N+1, response N+3, next accept N+4
      tick();
      model_rdata = 32'h0000_0001;
      expect_rsp(32'h1, 1'b0, 1'b0);
      issue(mk_cmd(1'b0, 32'h0, 32'h0, 4'hF));
      @(negedge clk);
      check("rd_ren_n1", sys_ren_o, 1);
      check("rd_wen_n1", sys_wen_o, 0);
      check("rd_cmd_ready_busy", cmd_ready_o, 0);
      @(negedge clk);
      check("rd_ren_n2", sys_ren_o, 0);
      check("rd_rsp_valid_n2", rsp_valid_o, 0);
      @(negedge clk);
      check("rd_rsp_valid_n3", rsp_valid_o, 1);
      @(negedge clk);
      check("rd_cmd_ready_n4", cmd_ready_o, 1);
      check("rd_rsp_valid_n4", rsp_valid_o, 0);

      // Write addr 0x30: single wen pulse, fields stable through the ack, rdata returns 0
      tick();
      model_rdata = 32'h1234_5678;
      expect_rsp(32'h0, 1'b0, 1'b0);
      issue(mk_cmd(1'b1, 32'h30, 32'h5A, 4'hF));
      @(negedge clk);
      check("wr_wen_n1", sys_wen_o, 1);
      check("wr_ren_n1", sys_ren_o, 0);
      check("wr_addr_n1", sys_addr_o, 32'h30);
      check("wr_wdata_n1", sys_wdata_o, 32'h5A);
      check("wr_sel_n1", sys_sel_o, 4'hF);
      @(negedge clk);
      check("wr_wen_n2", sys_wen_o, 0);
      check("wr_addr_ack", sys_addr_o, 32'h30);
      check("wr_wdata_ack", sys_wdata_o, 32'h5A);
      @(negedge clk);
      check("wr_rsp_valid_n3", rsp_valid_o, 1);
      @(negedge clk);

      // Read acked together with sys_err: data kept, err=1
      tick();
      model_rdata = 32'hDEAD_BEEF;
      model_err   = 1'b1;
      expect_rsp(32'hDEAD_BEEF, 1'b1, 1'b0);
      issue(mk_cmd(1'b0, 32'h10, 32'h0, 4'hF));
      repeat (3) @(negedge clk);
      check("err_rsp_valid_n3", rsp_valid_o, 1);
      @(negedge clk);
      model_err = 1'b0;

      // Response backpressure for 20 cycles with a second command waiting
      tick();
      rsp_ready_i = 1'b0;
      model_rdata = 32'hCAFE_0001;
      expect_rsp(32'hCAFE_0001, 1'b0, 1'b0);
      issue(mk_cmd(1'b0, 32'h20, 32'h0, 4'hF));
      repeat (3) @(negedge clk);
      check("bp_rsp_valid", rsp_valid_o, 1);
      tick();
      drive(mk_cmd(1'b0, 32'h44, 32'h0, 4'hF));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid_o, 1);
         check("bp_hold_rdata", rsp_rdata_o, 32'hCAFE_0001);
         check("bp_cmd_ready", cmd_ready_o, 0);
         check("bp_no_strobe", sys_ren_o || sys_wen_o, 0);
      end
      model_rdata = 32'h0000_0044;
      expect_rsp(32'h44, 1'b0, 1'b0);
      tick();
      rsp_ready_i = 1'b1;
      wait_accept();
      @(negedge clk);
      check("bp_next_ren", sys_ren_o, 1);
      check("bp_next_addr", sys_addr_o, 32'h44);
      repeat (2) @(negedge clk);
      check("bp_next_rsp_valid", rsp_valid_o, 1);
      @(negedge clk);

      // sys_err without ack terminates WAIT with rdata 0
      tick();
      auto_ack = 1'b0;
      expect_rsp(32'h0, 1'b1, 1'b0);
      issue(mk_cmd(1'b0, 32'h58, 32'h0, 4'hF));
      tick();
      sys_err_i   = 1'b1;
      sys_rdata_i = 32'h99;
      tick();
      sys_err_i   = 1'b0;
      sys_rdata_i = '0;
      @(negedge clk);
      check("erronly_rsp_valid", rsp_valid_o, 1);
      @(negedge clk);

`ifdef SYS_BUS_INIT_TIMEOUT_EN
      // Silent responder: response 65 cycles after the strobe, err=1 tmo=1
      tick();
      expect_rsp(32'h0, 1'b1, 1'b1);
      issue(mk_cmd(1'b0, 32'h50, 32'h0, 4'hF));
      @(negedge clk);
      n = 0;
      while (!rsp_valid_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", n, TMO_CYC + 1);
`else
      // Silent responder: WAIT never ends on its own
      tick();
      expect_rsp(32'h77, 1'b0, 1'b0);
      issue(mk_cmd(1'b0, 32'h50, 32'h0, 4'hF));
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (rsp_valid_o) seen++;
      end
      check("silent_no_rsp", seen, 0);
      check("silent_cmd_ready", cmd_ready_o, 0);
      tick();
      sys_ack_i   = 1'b1;
      sys_rdata_i = 32'h77;
      tick();
      sys_ack_i   = 1'b0;
      sys_rdata_i = '0;
      @(negedge clk);
      check("silent_late_rsp_valid", rsp_valid_o, 1);
`endif

      // A stray ack while idle produces nothing
      repeat (10) tick();
      sys_ack_i   = 1'b1;
      sys_rdata_i = 32'hBAD;
      tick();
      sys_ack_i   = 1'b0;
      sys_rdata_i = '0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid_o) seen++;
      end
      check("stray_ack_no_rsp", seen, 0);
      check("stray_ack_cmd_ready", cmd_ready_o, 1);

`ifdef SYS_BUS_INIT_TIMEOUT_EN
      // Ack in the expiry cycle wins: tmo=0
      tick();
      expect_rsp(32'hA5A5, 1'b0, 1'b0);
      issue(mk_cmd(1'b0, 32'h54, 32'h0, 4'hF));
      repeat (TMO_CYC) tick();
      sys_ack_i   = 1'b1;
      sys_rdata_i = 32'hA5A5;
      tick();
      sys_ack_i   = 1'b0;
      sys_rdata_i = '0;
      @(negedge clk);
      check("expiry_ack_rsp_valid", rsp_valid_o, 1);
      @(negedge clk);
`endif

      // Reset pulsed during WAIT: outputs drop in the same cycle, transaction lost
      tick();
      issue(mk_cmd(1'b0, 32'h60, 32'h0, 4'hF));
      tick();
      #2;
      rst_i = 1'b1;
      #1;
      check("rstw_ren", sys_ren_o, 0);
      check("rstw_wen", sys_wen_o, 0);
      check("rstw_rsp_valid", rsp_valid_o, 0);
      check("rstw_cmd_ready", cmd_ready_o, 0);
      check("rstw_sys_addr", sys_addr_o, 0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("rstw_post_cmd_ready", cmd_ready_o, 1);
      auto_ack    = 1'b1;
      model_rdata = 32'h0000_0001;
      expect_rsp(32'h1, 1'b0, 1'b0);
      tick();
      issue(mk_cmd(1'b0, 32'h0, 32'h0, 4'hF));
      @(negedge clk);
      check("rstw_new_ren", sys_ren_o, 1);
      repeat (2) @(negedge clk);
      check("rstw_new_rsp_valid", rsp_valid_o, 1);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
